// File: rtl/shift_sequencer.sv
// Load-then-shift controller for the W-bit right-shift register datapath.
// Drives load_n / shift_right / asr cycle by cycle and captures the final datapath value.
module shift_sequencer #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  load_val,
  input  logic [CW-1:0] shift_cnt,
  input  logic          arith,
  input  logic [W-1:0]  shifter_q,
  output logic [W-1:0]  ctl_load_val,
  output logic          ctl_load_n,
  output logic          ctl_shift_right,
  output logic          ctl_asr,
  output logic [W-1:0]  result,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] W_CNT = CW'(W);

  state_t        state_q, state_d;
  logic [W-1:0]  operand_q, operand_d;
  logic [W-1:0]  result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          arith_q, arith_d;
  logic          load_n_q, load_n_d;
  logic          shift_q, shift_d;
  logic          asr_q, asr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    arith_d   = arith_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          operand_d = load_val;
          arith_d   = arith;
          cnt_d     = (shift_cnt > W_CNT) ? W_CNT : shift_cnt;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = (cnt_q != '0) ? S_SHIFT : S_CAPTURE;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        // Leave on the last shift cycle; <= also guards against a stray zero count.
        if (cnt_q <= 1) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        result_d = shifter_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so decode them from the state being entered.
    load_n_d = (state_d != S_LOAD);
    shift_d  = (state_d == S_SHIFT);
    asr_d    = (state_d == S_SHIFT) && arith_d;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      arith_q   <= 1'b0;
      load_n_q  <= 1'b1;
      shift_q   <= 1'b0;
      asr_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      arith_q   <= arith_d;
      load_n_q  <= load_n_d;
      shift_q   <= shift_d;
      asr_q     <= asr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ctl_load_val    = operand_q;
  assign ctl_load_n      = load_n_q;
  assign ctl_shift_right = shift_q;
  assign ctl_asr         = asr_q;
  assign result          = result_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with a behavioural model of the shift-register datapath attached.
// Expected results are queued at launch and popped when done pulses.
module tb_shift_sequencer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  load_val;
  logic [CW-1:0] shift_cnt;
  logic          arith;
  logic [W-1:0]  shifter_q = '0;
  logic [W-1:0]  ctl_load_val;
  logic          ctl_load_n;
  logic          ctl_shift_right;
  logic          ctl_asr;
  logic [W-1:0]  result;
  logic          busy;
  logic          done;

  int checks = 0;
  int passes = 0;
  logic [W-1:0] sb_q[$];

  shift_sequencer #(.W(W), .CW(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .load_val        (load_val),
    .shift_cnt       (shift_cnt),
    .arith           (arith),
    .shifter_q       (shifter_q),
    .ctl_load_val    (ctl_load_val),
    .ctl_load_n      (ctl_load_n),
    .ctl_shift_right (ctl_shift_right),
    .ctl_asr         (ctl_asr),
    .result          (result),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // Datapath: hold / shift right / parallel load cells.
  always @(posedge clk) begin
    if (!ctl_load_n)
      shifter_q <= ctl_load_val;
    else if (ctl_shift_right)
      shifter_q <= {ctl_asr & shifter_q[W-1], shifter_q[W-1:1]};
  end

  function automatic logic [W-1:0] exp_result(input logic [W-1:0] v, input int c, input logic a);
    logic [W-1:0] r;
    int n;
    r = v;
    n = (c > W) ? W : c;
    for (int i = 0; i < n; i++) r = {a & r[W-1], r[W-1:1]};
    return r;
  endfunction

  // Drive a request in an IDLE cycle; returns one step later, inside cycle 1.
  task automatic launch(input logic [W-1:0] v, input logic [CW-1:0] c, input logic a, input bit hold);
    load_val  = v;
    shift_cnt = c;
    arith     = a;
    start     = 1'b1;
    sb_q.push_back(exp_result(v, int'(c), a));
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Observe from the current cycle until done; done_cyc is -1 if the budget runs out.
  task automatic wait_done(input int first_cyc, output int done_cyc, output int loads,
                           output int shifts, output int asrs);
    int c;
    c = first_cyc;
    done_cyc = -1; loads = 0; shifts = 0; asrs = 0;
    for (int k = 0; k < 40; k++) begin
      if (!ctl_load_n) loads++;
      if (ctl_shift_right) shifts++;
      if (ctl_asr) asrs++;
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; load_val = '0; shift_cnt = '0; arith = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passes++;
    checks++; if (ctl_load_n !== 1'b1) $display("FAIL reset_load_n got=%b exp=1", ctl_load_n); else passes++;
    checks++; if (ctl_shift_right !== 1'b0) $display("FAIL reset_shift got=%b exp=0", ctl_shift_right); else passes++;
    checks++; if (ctl_asr !== 1'b0) $display("FAIL reset_asr got=%b exp=0", ctl_asr); else passes++;
    checks++; if (result !== 8'h00) $display("FAIL reset_result got=%h exp=00", result); else passes++;
    checks++; if (ctl_load_val !== 8'h00) $display("FAIL reset_load_val got=%h exp=00", ctl_load_val); else passes++;
    $display("reset: busy=%b done=%b load_n=%b result=%h", busy, done, ctl_load_n, result);
    reset = 1'b1;
  endtask

  task automatic test_pure_load;
    int dc, ld, sh, as;
    logic [W-1:0] exp;
    @(posedge clk); #1;
    launch(8'hA5, 4'd0, 1'b0, 1'b0);
    wait_done(1, dc, ld, sh, as);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    checks++; if (dc !== 3) $display("FAIL pure_load_done_cycle got=%0d exp=3", dc); else passes++;
    checks++; if (ld !== 1) $display("FAIL pure_load_load_cycles got=%0d exp=1", ld); else passes++;
    checks++; if (sh !== 0) $display("FAIL pure_load_shift_cycles got=%0d exp=0", sh); else passes++;
    checks++; if (result !== exp) $display("FAIL pure_load_result got=%h exp=%h", result, exp); else passes++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL pure_load_busy_c4 got=%b exp=0", busy); else passes++;
    $display("op A5 cnt=0 lsr: done_cycle=%0d result=%h exp=%h", dc, result, exp);
  endtask

  task automatic test_shift(input logic [W-1:0] v, input logic [CW-1:0] c, input logic a);
    int dc, ld, sh, as, n;
    logic [W-1:0] exp;
    n = (int'(c) > W) ? W : int'(c);
    @(posedge clk); #1;
    launch(v, c, a, 1'b0);
    wait_done(1, dc, ld, sh, as);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    checks++; if (dc !== 3 + n) $display("FAIL shift_done_cycle got=%0d exp=%0d", dc, 3 + n); else passes++;
    checks++; if (ld !== 1) $display("FAIL shift_load_cycles got=%0d exp=1", ld); else passes++;
    checks++; if (sh !== n) $display("FAIL shift_cycles got=%0d exp=%0d", sh, n); else passes++;
    checks++; if (as !== (a ? n : 0)) $display("FAIL shift_asr_cycles got=%0d exp=%0d", as, a ? n : 0); else passes++;
    checks++; if (result !== exp) $display("FAIL shift_result got=%h exp=%h", result, exp); else passes++;
    $display("op %h cnt=%0d %s: done_cycle=%0d shifts=%0d result=%h exp=%h",
             v, c, a ? "asr" : "lsr", dc, sh, result, exp);
  endtask

  task automatic test_busy;
    int dc, ld, sh, as;
    logic [W-1:0] exp;
    @(posedge clk); #1;
    launch(8'h0F, 4'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; load_val = 8'hFF; shift_cnt = 4'd0; arith = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, dc, ld, sh, as);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    checks++; if (dc !== 5) $display("FAIL busy_done_cycle got=%0d exp=5", dc); else passes++;
    checks++; if (result !== exp) $display("FAIL busy_result got=%h exp=%h", result, exp); else passes++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL busy_idle_c6 got=%b exp=0", busy); else passes++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || ctl_load_n !== 1'b1)
      $display("FAIL busy_not_queued busy=%b load_n=%b exp busy=0 load_n=1", busy, ctl_load_n); else passes++;
    checks++; if (result !== 8'h03) $display("FAIL busy_result_hold got=%h exp=03", result); else passes++;
    $display("op 0F cnt=2 with ignored start: done_cycle=%0d result=%h exp=%h", dc, result, exp);
  endtask

  task automatic test_back_to_back;
    int dc, ld, sh, as;
    logic [W-1:0] exp;
    @(posedge clk); #1;
    launch(8'h3C, 4'd1, 1'b0, 1'b1);
    wait_done(1, dc, ld, sh, as);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    checks++; if (dc !== 4) $display("FAIL b2b_first_done_cycle got=%0d exp=4", dc); else passes++;
    checks++; if (result !== exp) $display("FAIL b2b_first_result got=%h exp=%h", result, exp); else passes++;
    $display("op 3C cnt=1 lsr (held start): done_cycle=%0d result=%h exp=%h", dc, result, exp);
    load_val = 8'h81; shift_cnt = 4'd1; arith = 1'b1;
    sb_q.push_back(exp_result(8'h81, 1, 1'b1));
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_c5 got=%b exp=0", busy); else passes++;
    @(posedge clk); #1;
    checks++; if (ctl_load_n !== 1'b0) $display("FAIL b2b_second_load_c6 got=%b exp=0", ctl_load_n); else passes++;
    start = 1'b0;
    wait_done(6, dc, ld, sh, as);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
    checks++; if (dc !== 9) $display("FAIL b2b_second_done_cycle got=%0d exp=9", dc); else passes++;
    checks++; if (result !== exp) $display("FAIL b2b_second_result got=%h exp=%h", result, exp); else passes++;
    checks++; if (sb_q.size() !== 0) $display("FAIL b2b_scoreboard_left got=%0d exp=0", sb_q.size()); else passes++;
    $display("op 81 cnt=1 asr (back-to-back): done_cycle=%0d result=%h exp=%h", dc, result, exp);
  endtask

  task automatic test_reset_mid_shift;
    int seen_done;
    @(posedge clk); #1;
    load_val = 8'hAA; shift_cnt = 4'd5; arith = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (ctl_shift_right !== 1'b1) $display("FAIL rst_mid_in_shift got=%b exp=1", ctl_shift_right); else passes++;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else passes++;
    checks++; if (ctl_shift_right !== 1'b0) $display("FAIL rst_mid_shift got=%b exp=0", ctl_shift_right); else passes++;
    checks++; if (result !== 8'h00) $display("FAIL rst_mid_result got=%h exp=00", result); else passes++;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) seen_done++;
      @(posedge clk); #1;
    end
    checks++; if (seen_done !== 0) $display("FAIL rst_mid_no_done got=%0d exp=0", seen_done); else passes++;
    $display("op AA cnt=5 aborted by reset: busy=%b result=%h done_pulses=%0d", busy, result, seen_done);
  endtask

  initial begin
    test_reset;
    test_pure_load;
    test_shift(8'h96, 4'd3, 1'b0);
    test_shift(8'h96, 4'd3, 1'b1);
    test_shift(8'h80, 4'd15, 1'b1);
    test_shift(8'h80, 4'd15, 1'b0);
    test_busy;
    test_back_to_back;
    test_reset_mid_shift;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
